rename_dispatch_nw: RTL and testbench

//  N-wide rename/dispatch stage; successor to the scalar rename stage. Buffers one decode group of WIDTH

---
 rtl/rename_dispatch_nw_pkg.sv | 78 +++++++
 rtl/rename_dispatch_nw_src_bypass.sv | 46 ++++
 rtl/rename_dispatch_nw.sv | 269 ++++++++++++++++++++++++++
 tb/tb_rename_dispatch_nw.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_dispatch_nw_pkg.sv
// Shared types for the N-wide rename/dispatch stage: decoded-slot payload, RS packet, FU classes.
package rename_dispatch_nw_pkg;

  localparam int unsigned PREG_W         = 6;
  localparam int unsigned AREG_W         = 5;
  localparam int unsigned ROB_DEPTH      = 16;
  localparam int unsigned ROB_IDX_W      = $clog2(ROB_DEPTH);
  localparam int unsigned ROB_DATA_WIDTH = 1 + AREG_W + PREG_W;
  localparam int unsigned NUM_FU         = 5;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_DIV = 3'd2,
    FU_MEM = 3'd3,
    FU_BR  = 3'd4
  } fu_sel_t;

  typedef enum logic {
    M2_RS2_OUT = 1'b0,
    M2_IMM_OUT = 1'b1
  } alu_m2_sel_t;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
    logic [AREG_W-1:0] rd;
    logic              regf_we;
    alu_m2_sel_t       alu_m2_sel;
    logic [31:0]       imm;
  } id_ex_stage_reg_t;

  // Superset of the fields every RS class needs, tagged with the target class.
  typedef struct packed {
    fu_sel_t              fu;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    pd;
    logic [AREG_W-1:0]    rd;
    logic [PREG_W-1:0]    ps1;
    logic                 ps1_ready;
    logic [PREG_W-1:0]    ps2;
    logic                 ps2_ready;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    alu_m2_sel_t          alu_m2_sel;
    logic [31:0]          imm;
  } rs_pkt_t;

  function automatic fu_sel_t fu_class(input logic [6:0] opcode, input logic [2:0] funct3,
                                       input logic [6:0] funct7);
    fu_sel_t c;
    c = FU_ALU;
    if (opcode == OP_REG && funct7 == 7'b0000001) begin
      c = (funct3 < 3'd4) ? FU_MUL : FU_DIV;
    end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
      c = FU_MEM;
    end else if (opcode == OP_BR || opcode == OP_JAL || opcode == OP_JALR) begin
      c = FU_BR;
    end
    return c;
  endfunction

  function automatic logic needs_preg(input logic regf_we, input logic [AREG_W-1:0] rd);
    return regf_we && (rd != '0);
  endfunction

endpackage

// File: rtl/rename_dispatch_nw_src_bypass.sv
// Per-lane source override: a source matching the rd of the youngest older renaming lane takes its pd.
module rename_src_bypass
  import rename_dispatch_nw_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LANE  = 0
) (
  input  logic [AREG_W-1:0]             rs1,
  input  logic [AREG_W-1:0]             rs2,
  input  logic [PREG_W-1:0]             rat_ps1,
  input  logic [PREG_W-1:0]             rat_ps2,
  input  logic                          rat_ps1_valid,
  input  logic                          rat_ps2_valid,
  input  logic [WIDTH-1:0][AREG_W-1:0]  older_rd,
  input  logic [WIDTH-1:0][PREG_W-1:0]  older_pd,
  input  logic [WIDTH-1:0]              older_wr,
  output logic [PREG_W-1:0]             ps1,
  output logic [PREG_W-1:0]             ps2,
  output logic                          ps1_ready,
  output logic                          ps2_ready
);

  localparam logic [WIDTH-1:0] OLDER_MASK = WIDTH'((64'd1 << LANE) - 64'd1);

  logic [WIDTH-1:0] cand;
  assign cand = older_wr & OLDER_MASK;

  // Ascending scan so the youngest older writer wins.
  always_comb begin
    ps1       = rat_ps1;
    ps2       = rat_ps2;
    ps1_ready = rat_ps1_valid;
    ps2_ready = rat_ps2_valid;
    for (int k = 0; k < WIDTH; k++) begin
      if (cand[k] && older_rd[k] != '0 && older_rd[k] == rs1) begin
        ps1       = older_pd[k];
        ps1_ready = 1'b0;
      end
      if (cand[k] && older_rd[k] != '0 && older_rd[k] == rs2) begin
        ps2       = older_pd[k];
        ps2_ready = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rename_dispatch_nw.sv
// N-wide rename/dispatch: buffers one decode group, dispatches the longest in-order prefix that fits.
// Optional DISPATCH_PERF_CTR_EN adds dispatch/stall performance counters.
module rename_dispatch_nw
  import rename_dispatch_nw_pkg::*;
#(
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [WIDTH-1:0]                   dec_valid,
  input  id_ex_stage_reg_t [WIDTH-1:0]       dec_inst,
  output logic                               dec_ready,
  input  logic                               jump_commit,
  input  logic [CW-1:0]                      fl_avail,
  input  logic [WIDTH-1:0][PREG_W-1:0]       fl_pd,
  output logic [CW-1:0]                      fl_dequeue,
  output logic [WIDTH-1:0][AREG_W-1:0]       rat_rs1,
  output logic [WIDTH-1:0][AREG_W-1:0]       rat_rs2,
  input  logic [WIDTH-1:0][PREG_W-1:0]       rat_ps1,
  input  logic [WIDTH-1:0][PREG_W-1:0]       rat_ps2,
  input  logic [WIDTH-1:0]                   rat_ps1_valid,
  input  logic [WIDTH-1:0]                   rat_ps2_valid,
  output logic [WIDTH-1:0]                   rat_we,
  output logic [WIDTH-1:0][AREG_W-1:0]       rat_rd,
  output logic [WIDTH-1:0][PREG_W-1:0]       rat_pd,
  input  logic [CW-1:0]                      rob_space,
  input  logic [WIDTH-1:0][ROB_IDX_W-1:0]    rob_idx,
  output logic [CW-1:0]                      rob_enqueue,
  output logic [WIDTH-1:0][ROB_DATA_WIDTH-1:0] rob_data,
  input  logic [NUM_FU-1:0][CW-1:0]          rs_space,
  output logic [WIDTH-1:0]                   disp_valid,
  output fu_sel_t [WIDTH-1:0]                disp_fu,
  output rs_pkt_t [WIDTH-1:0]                disp_pkt
`ifdef DISPATCH_PERF_CTR_EN
  ,
  output logic [31:0]                        perf_disp_cnt,
  output logic [31:0]                        perf_stall_fl,
  output logic [31:0]                        perf_stall_rob,
  output logic [31:0]                        perf_stall_rs
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_PARTIAL} state_t;

  state_t                        state_q, state_d;
  id_ex_stage_reg_t [WIDTH-1:0]  slot_q;
  logic [WIDTH-1:0]              slot_v_q, slot_v_d;
  logic [CW-1:0]                 head_q, head_d;
  logic                          load_grp;

  id_ex_stage_reg_t [WIDTH-1:0]  lane_inst;
  logic [WIDTH-1:0]              lane_v, lane_wr, disp, wr_disp;
  fu_sel_t [WIDTH-1:0]           lane_fu;
  logic [WIDTH-1:0][AREG_W-1:0]  lane_rd;
  logic [WIDTH-1:0][PREG_W-1:0]  lane_pd, byp_ps1, byp_ps2;
  logic [WIDTH-1:0]              byp_rdy1, byp_rdy2;
  logic [CW-1:0]                 n_disp, n_pend, n_preg;

  // Lane k views buffer slot head+k.
  always_comb begin
    lane_inst = '0;
    lane_v    = '0;
    for (int k = 0; k < WIDTH; k++) begin
      for (int s = 0; s < WIDTH; s++) begin
        if (int'(head_q) + k == s) begin
          lane_inst[k] = slot_q[s];
          lane_v[k]    = slot_v_q[s];
        end
      end
    end
  end

  // In-order prefix selection against free-list, ROB and per-class RS capacity.
  always_comb begin
    int   rs_cnt [NUM_FU];
    int   np;
    int   nd;
    int   npend;
    logic ok;
    logic rs_ok;
    disp    = '0;
    lane_pd = '0;
    lane_wr = '0;
    lane_rd = '0;
    np      = 0;
    nd      = 0;
    npend   = 0;
    ok      = !jump_commit;
    rs_ok   = 1'b0;
    for (int c = 0; c < NUM_FU; c++) rs_cnt[c] = 0;
    for (int k = 0; k < WIDTH; k++) begin
      lane_fu[k] = fu_class(lane_inst[k].opcode, lane_inst[k].funct3, lane_inst[k].funct7);
      lane_wr[k] = needs_preg(lane_inst[k].regf_we, lane_inst[k].rd);
      lane_rd[k] = lane_inst[k].rd;
      if (lane_v[k]) npend++;
      rs_ok = 1'b0;
      for (int c = 0; c < NUM_FU; c++) begin
        if (int'(lane_fu[k]) == c) rs_ok = (rs_cnt[c] + 1 <= int'(rs_space[c]));
      end
      ok = ok && lane_v[k] && rs_ok
            && (np + (lane_wr[k] ? 1 : 0) <= int'(fl_avail))
            && (k + 1 <= int'(rob_space));
      if (ok) begin
        disp[k] = 1'b1;
        nd++;
        for (int c = 0; c < NUM_FU; c++) begin
          if (int'(lane_fu[k]) == c) rs_cnt[c]++;
        end
        if (lane_wr[k]) begin
          for (int j = 0; j < WIDTH; j++) begin
            if (j == np) lane_pd[k] = fl_pd[j];
          end
          np++;
        end
      end
    end
    n_disp = CW'(nd);
    n_preg = CW'(np);
    n_pend = CW'(npend);
  end

  assign wr_disp     = disp & lane_wr;
  assign disp_valid  = disp;
  assign fl_dequeue  = n_preg;
  assign rob_enqueue = n_disp;

  for (genvar g = 0; g < WIDTH; g++) begin : g_byp
    rename_src_bypass #(
      .WIDTH (WIDTH),
      .LANE  (g)
    ) u_byp (
      .rs1           (lane_inst[g].rs1),
      .rs2           (lane_inst[g].rs2),
      .rat_ps1       (rat_ps1[g]),
      .rat_ps2       (rat_ps2[g]),
      .rat_ps1_valid (rat_ps1_valid[g]),
      .rat_ps2_valid (rat_ps2_valid[g]),
      .older_rd      (lane_rd),
      .older_pd      (lane_pd),
      .older_wr      (wr_disp),
      .ps1           (byp_ps1[g]),
      .ps2           (byp_ps2[g]),
      .ps1_ready     (byp_rdy1[g]),
      .ps2_ready     (byp_rdy2[g])
    );
  end

  // RAT, ROB and RS outputs; an older writer shadowed by a younger same-rd writer skips the RAT.
  always_comb begin
    rs_pkt_t pkt;
    logic    shadow;
    rat_rs1  = '0;
    rat_rs2  = '0;
    rat_we   = '0;
    rat_rd   = '0;
    rat_pd   = '0;
    rob_data = '0;
    disp_pkt = '0;
    pkt      = '0;
    shadow   = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      disp_fu[k] = FU_ALU;
      if (lane_v[k]) begin
        rat_rs1[k] = lane_inst[k].rs1;
        rat_rs2[k] = lane_inst[k].rs2;
      end
      shadow = 1'b0;
      for (int m = 0; m < WIDTH; m++) begin
        if (m > k && wr_disp[m] && lane_rd[m] == lane_rd[k]) shadow = 1'b1;
      end
      if (wr_disp[k] && !shadow) begin
        rat_we[k] = 1'b1;
        rat_rd[k] = lane_rd[k];
        rat_pd[k] = lane_pd[k];
      end
      if (disp[k]) begin
        disp_fu[k]     = lane_fu[k];
        rob_data[k]    = {1'b0, lane_rd[k], lane_pd[k]};
        pkt            = '0;
        pkt.fu         = lane_fu[k];
        pkt.rob_idx    = rob_idx[k];
        pkt.pd         = lane_pd[k];
        pkt.rd         = lane_rd[k];
        pkt.ps1        = byp_ps1[k];
        pkt.ps1_ready  = byp_rdy1[k];
        pkt.ps2        = byp_ps2[k];
        pkt.ps2_ready  = byp_rdy2[k];
        pkt.opcode     = lane_inst[k].opcode;
        pkt.funct3     = lane_inst[k].funct3;
        pkt.funct7     = lane_inst[k].funct7;
        pkt.alu_m2_sel = lane_inst[k].alu_m2_sel;
        pkt.imm        = lane_inst[k].imm;
        if (lane_fu[k] == FU_ALU && lane_inst[k].alu_m2_sel == M2_IMM_OUT) begin
          pkt.ps2       = '0;
          pkt.ps2_ready = 1'b1;
        end
        disp_pkt[k] = pkt;
      end
    end
  end

  // Group buffer control; a flush dominates acceptance.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    slot_v_d  = slot_v_q;
    load_grp  = 1'b0;
    dec_ready = !jump_commit && (state_q == S_EMPTY || n_disp == n_pend);
    if (jump_commit) begin
      state_d  = S_EMPTY;
      head_d   = '0;
      slot_v_d = '0;
    end else if (dec_ready && (|dec_valid)) begin
      load_grp = 1'b1;
      state_d  = S_FULL;
      head_d   = '0;
      slot_v_d = dec_valid;
    end else if (state_q != S_EMPTY && n_disp == n_pend) begin
      state_d  = S_EMPTY;
      head_d   = '0;
      slot_v_d = '0;
    end else if (n_disp != '0) begin
      state_d = S_PARTIAL;
      head_d  = head_q + n_disp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      head_q   <= '0;
      slot_v_q <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      slot_v_q <= slot_v_d;
      if (load_grp) slot_q <= dec_inst;
    end
  end

`ifdef DISPATCH_PERF_CTR_EN
  logic lane0_blocked, stall_fl, stall_rob, stall_rs;

  // Attribute a blocked lane 0 to the first failing resource: free list, ROB, then RS.
  always_comb begin
    lane0_blocked = lane_v[0] && !disp[0] && !jump_commit;
    stall_fl      = lane0_blocked && lane_wr[0] && (fl_avail == '0);
    stall_rob     = lane0_blocked && !stall_fl && (rob_space == '0);
    stall_rs      = lane0_blocked && !stall_fl && !stall_rob;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_disp_cnt  <= '0;
      perf_stall_fl  <= '0;
      perf_stall_rob <= '0;
      perf_stall_rs  <= '0;
    end else begin
      perf_disp_cnt  <= perf_disp_cnt + 32'(n_disp);
      perf_stall_fl  <= perf_stall_fl + 32'(stall_fl);
      perf_stall_rob <= perf_stall_rob + 32'(stall_rob);
      perf_stall_rs  <= perf_stall_rs + 32'(stall_rs);
    end
  end
`endif

endmodule

// File: tb/tb_rename_dispatch_nw.sv
// Directed bench for rename_dispatch_nw (WIDTH=2): renaming, bypass, capacity limits, flush and reset.
module tb_rename_dispatch_nw;
  import rename_dispatch_nw_pkg::*;

  localparam int unsigned WIDTH  = 2;
  localparam int unsigned CW     = 2;
  localparam logic [6:0]  OPC_IMM = 7'b0010011;

  logic                                clk;
  logic                                rst_n;
  logic [WIDTH-1:0]                    dec_valid;
  id_ex_stage_reg_t [WIDTH-1:0]        dec_inst;
  logic                                dec_ready;
  logic                                jump_commit;
  logic [CW-1:0]                       fl_avail;
  logic [WIDTH-1:0][PREG_W-1:0]        fl_pd;
  logic [CW-1:0]                       fl_dequeue;
  logic [WIDTH-1:0][AREG_W-1:0]        rat_rs1, rat_rs2;
  logic [WIDTH-1:0][PREG_W-1:0]        rat_ps1, rat_ps2;
  logic [WIDTH-1:0]                    rat_ps1_valid, rat_ps2_valid;
  logic [WIDTH-1:0]                    rat_we;
  logic [WIDTH-1:0][AREG_W-1:0]        rat_rd;
  logic [WIDTH-1:0][PREG_W-1:0]        rat_pd;
  logic [CW-1:0]                       rob_space;
  logic [WIDTH-1:0][ROB_IDX_W-1:0]     rob_idx;
  logic [CW-1:0]                       rob_enqueue;
  logic [WIDTH-1:0][ROB_DATA_WIDTH-1:0] rob_data;
  logic [NUM_FU-1:0][CW-1:0]           rs_space;
  logic [WIDTH-1:0]                    disp_valid;
  fu_sel_t [WIDTH-1:0]                 disp_fu;
  rs_pkt_t [WIDTH-1:0]                 disp_pkt;

  int n_chk  = 0;
  int n_fail = 0;

  rename_dispatch_nw #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dec_valid     (dec_valid),
    .dec_inst      (dec_inst),
    .dec_ready     (dec_ready),
    .jump_commit   (jump_commit),
    .fl_avail      (fl_avail),
    .fl_pd         (fl_pd),
    .fl_dequeue    (fl_dequeue),
    .rat_rs1       (rat_rs1),
    .rat_rs2       (rat_rs2),
    .rat_ps1       (rat_ps1),
    .rat_ps2       (rat_ps2),
    .rat_ps1_valid (rat_ps1_valid),
    .rat_ps2_valid (rat_ps2_valid),
    .rat_we        (rat_we),
    .rat_rd        (rat_rd),
    .rat_pd        (rat_pd),
    .rob_space     (rob_space),
    .rob_idx       (rob_idx),
    .rob_enqueue   (rob_enqueue),
    .rob_data      (rob_data),
    .rs_space      (rs_space),
    .disp_valid    (disp_valid),
    .disp_fu       (disp_fu),
    .disp_pkt      (disp_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic id_ex_stage_reg_t ins(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic we, input alu_m2_sel_t m2, input logic [31:0] imm);
    id_ex_stage_reg_t r;
    r.opcode = op; r.funct3 = f3; r.funct7 = f7; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.regf_we = we; r.alu_m2_sel = m2; r.imm = imm;
    return r;
  endfunction

  function automatic id_ex_stage_reg_t add_i(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return ins(OP_REG, 3'd0, 7'd0, rd, a, b, 1'b1, M2_RS2_OUT, 32'd0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    dec_valid   = '0;
    dec_inst    = '0;
    jump_commit = 1'b0;
    fl_avail    = 2'd2;
    fl_pd       = '0;
    rat_ps1[0]  = 6'd30; rat_ps1[1] = 6'd31;
    rat_ps2[0]  = 6'd40; rat_ps2[1] = 6'd41;
    rat_ps1_valid = 2'b11;
    rat_ps2_valid = 2'b11;
    rob_space   = 2'd2;
    rob_idx[0]  = 4'd4; rob_idx[1] = 4'd5;
    for (int c = 0; c < NUM_FU; c++) rs_space[c] = 2'd2;

    // Reset state
    step(); step();
    #1;
    chk("rst_dec_ready", 64'(dec_ready), 64'd1);
    chk("rst_disp_valid", 64'(disp_valid), 64'd0);
    chk("rst_fl_dequeue", 64'(fl_dequeue), 64'd0);
    chk("rst_rob_enqueue", 64'(rob_enqueue), 64'd0);
    chk("rst_rat_we", 64'(rat_we), 64'd0);
    rst_n = 1'b1;

    // 1: two independent adds
    dec_valid = 2'b11; dec_inst[0] = add_i(5'd3, 5'd1, 5'd2); dec_inst[1] = add_i(5'd4, 5'd1, 5'd2);
    fl_pd[0] = 6'd8; fl_pd[1] = 6'd9;
    #1 chk("t1_accept_ready", 64'(dec_ready), 64'd1);
    step(); dec_valid = '0; #1;
    chk("t1_disp_valid", 64'(disp_valid), 64'b11);
    chk("t1_pd0", 64'(disp_pkt[0].pd), 64'd8);
    chk("t1_pd1", 64'(disp_pkt[1].pd), 64'd9);
    chk("t1_fl_dequeue", 64'(fl_dequeue), 64'd2);
    chk("t1_rob_enqueue", 64'(rob_enqueue), 64'd2);
    chk("t1_rat_we", 64'(rat_we), 64'b11);
    chk("t1_rob_idx1", 64'(disp_pkt[1].rob_idx), 64'd5);
    chk("t1_rob_data0", 64'(rob_data[0]), 64'({1'b0, 5'd3, 6'd8}));
    chk("t1_ps1_lane0", 64'(disp_pkt[0].ps1), 64'd30);
    chk("t1_ps1_rdy_lane0", 64'(disp_pkt[0].ps1_ready), 64'd1);
    chk("t1_dec_ready", 64'(dec_ready), 64'd1);

    // 2: intra-group dependency and same-rd writers
    step();
    dec_valid = 2'b11; dec_inst[0] = add_i(5'd5, 5'd1, 5'd2); dec_inst[1] = add_i(5'd5, 5'd5, 5'd5);
    fl_pd[0] = 6'd12; fl_pd[1] = 6'd13;
    step(); dec_valid = '0; #1;
    chk("t2_ps1_lane1", 64'(disp_pkt[1].ps1), 64'd12);
    chk("t2_ps1_rdy_lane1", 64'(disp_pkt[1].ps1_ready), 64'd0);
    chk("t2_ps2_lane1", 64'(disp_pkt[1].ps2), 64'd12);
    chk("t2_ps2_rdy_lane1", 64'(disp_pkt[1].ps2_ready), 64'd0);
    chk("t2_rat_we", 64'(rat_we), 64'b10);
    chk("t2_rat_pd1", 64'(rat_pd[1]), 64'd13);
    chk("t2_pd1", 64'(disp_pkt[1].pd), 64'd13);
    chk("t2_ps1_lane0", 64'(disp_pkt[0].ps1), 64'd30);

    // 3: free list limits to one writer, remainder held
    step();
    dec_valid = 2'b11; dec_inst[0] = add_i(5'd7, 5'd1, 5'd2); dec_inst[1] = add_i(5'd8, 5'd1, 5'd2);
    fl_pd[0] = 6'd20; fl_pd[1] = 6'd21;
    step(); dec_valid = '0; fl_avail = 2'd1; #1;
    chk("t3a_disp_valid", 64'(disp_valid), 64'b01);
    chk("t3a_fl_dequeue", 64'(fl_dequeue), 64'd1);
    chk("t3a_dec_ready", 64'(dec_ready), 64'd0);
    chk("t3a_pd0", 64'(disp_pkt[0].pd), 64'd20);
    step();
    fl_pd[0] = 6'd21; fl_pd[1] = 6'd22;
    dec_valid = 2'b11;
    dec_inst[0] = ins(OP_REG, 3'd0, 7'b0000001, 5'd9, 5'd1, 5'd2, 1'b1, M2_RS2_OUT, 32'd0);
    dec_inst[1] = add_i(5'd10, 5'd1, 5'd2);
    rs_space[FU_MUL] = 2'd0;
    #1;
    chk("t3b_disp_valid", 64'(disp_valid), 64'b01);
    chk("t3b_rd", 64'(disp_pkt[0].rd), 64'd8);
    chk("t3b_pd", 64'(disp_pkt[0].pd), 64'd21);
    chk("t3b_dec_ready", 64'(dec_ready), 64'd1);
    chk("t3b_rat_we", 64'(rat_we), 64'b01);

    // 4: MUL class full blocks lane 0 and everything behind it
    step(); dec_valid = '0; fl_avail = 2'd2; #1;
    chk("t4a_disp_valid", 64'(disp_valid), 64'b00);
    chk("t4a_dec_ready", 64'(dec_ready), 64'd0);
    chk("t4a_rob_enqueue", 64'(rob_enqueue), 64'd0);
    step(); rs_space[FU_MUL] = 2'd1; fl_pd[0] = 6'd24; fl_pd[1] = 6'd25; #1;
    chk("t4b_disp_valid", 64'(disp_valid), 64'b11);
    chk("t4b_fu0", 64'(disp_fu[0]), 64'(FU_MUL));
    chk("t4b_fu1", 64'(disp_fu[1]), 64'(FU_ALU));
    chk("t4b_pd0", 64'(disp_pkt[0].pd), 64'd24);
    chk("t4b_pd1", 64'(disp_pkt[1].pd), 64'd25);

    // 5: store and addi x0 consume no pregs
    step();
    rs_space[FU_MUL] = 2'd2;
    dec_valid = 2'b11;
    dec_inst[0] = ins(OP_STORE, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0, M2_IMM_OUT, 32'd0);
    dec_inst[1] = ins(OPC_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, M2_IMM_OUT, 32'd1);
    step(); dec_valid = '0; #1;
    chk("t5_disp_valid", 64'(disp_valid), 64'b11);
    chk("t5_fl_dequeue", 64'(fl_dequeue), 64'd0);
    chk("t5_rob_enqueue", 64'(rob_enqueue), 64'd2);
    chk("t5_rob_data0", 64'(rob_data[0]), 64'd0);
    chk("t5_rob_data1", 64'(rob_data[1]), 64'd0);
    chk("t5_rat_we", 64'(rat_we), 64'b00);
    chk("t5_fu0", 64'(disp_fu[0]), 64'(FU_MEM));
    chk("t5_store_ps2", 64'(disp_pkt[0].ps2), 64'd40);
    chk("t5_imm_ps2", 64'(disp_pkt[1].ps2), 64'd0);
    chk("t5_imm_ps2_rdy", 64'(disp_pkt[1].ps2_ready), 64'd1);

    // 6a: flush while partially dispatched, with a new group offered
    step();
    fl_avail = 2'd1; fl_pd[0] = 6'd30; fl_pd[1] = 6'd31;
    dec_valid = 2'b11; dec_inst[0] = add_i(5'd11, 5'd1, 5'd2); dec_inst[1] = add_i(5'd12, 5'd1, 5'd2);
    step(); dec_valid = '0;
    step();
    jump_commit = 1'b1;
    dec_valid = 2'b11; dec_inst[0] = add_i(5'd13, 5'd1, 5'd2); dec_inst[1] = add_i(5'd14, 5'd1, 5'd2);
    #1;
    chk("t6a_disp_valid", 64'(disp_valid), 64'b00);
    chk("t6a_fl_dequeue", 64'(fl_dequeue), 64'd0);
    chk("t6a_rob_enqueue", 64'(rob_enqueue), 64'd0);
    chk("t6a_rat_we", 64'(rat_we), 64'b00);
    chk("t6a_dec_ready", 64'(dec_ready), 64'd0);
    step(); jump_commit = 1'b0; dec_valid = '0; fl_avail = 2'd2; #1;
    chk("t6a_post_disp_valid", 64'(disp_valid), 64'b00);
    chk("t6a_post_dec_ready", 64'(dec_ready), 64'd1);

    // 6b: reset asserted mid-group
    fl_avail = 2'd1;
    dec_valid = 2'b11; dec_inst[0] = add_i(5'd15, 5'd1, 5'd2); dec_inst[1] = add_i(5'd16, 5'd1, 5'd2);
    step(); dec_valid = '0;
    step(); #1;
    chk("t6b_partial_disp", 64'(disp_valid), 64'b01);
    rst_n = 1'b0; #1;
    chk("t6b_rst_disp_valid", 64'(disp_valid), 64'b00);
    chk("t6b_rst_dec_ready", 64'(dec_ready), 64'd1);
    chk("t6b_rst_fl_dequeue", 64'(fl_dequeue), 64'd0);
    chk("t6b_rst_rat_we", 64'(rat_we), 64'b00);
    step(); rst_n = 1'b1; fl_avail = 2'd2;
    step(); #1;
    chk("t6b_post_disp_valid", 64'(disp_valid), 64'b00);
    chk("t6b_post_dec_ready", 64'(dec_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
